l1_mem_arbiter: RTL and testbench

Shares the single main-memory port between the instruction-cache controller (block refills only) and the data-cache controller (block refills and dirty writebacks). It sits between both L1 controllers and main memory and presents each controller with a private memory port using the same `memRen`/`memReadReady` handshake the controllers already speak. Arbitration is two-way round-robin, and each grant is held for one whole memory transaction.

---
 rtl/l1_mem_arbiter_pkg.sv | 18 +
 rtl/l1_mem_arbiter_if.sv | 50 +++++
 rtl/l1_mem_arbiter_rr_arb2.sv | 20 ++
 rtl/l1_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_l1_mem_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/l1_mem_arbiter_pkg.sv
// Shared L1 cache sizing, arbiter state encodings and grant encodings.
package l1_mem_arbiter_pkg;

  localparam int unsigned IMEM_BLOCK_ADDR_SIZE = 8;
  localparam int unsigned IBLOCK_SIZE_BITS     = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/l1_mem_arbiter_if.sv
// Bus bundle between the I/D L1 controllers, the arbiter and main memory.
interface l1_mem_arbiter_if
  import l1_mem_arbiter_pkg::*;
#(
  parameter int unsigned BLOCK_ADDR_W = IMEM_BLOCK_ADDR_SIZE,
  parameter int unsigned BLOCK_W      = IBLOCK_SIZE_BITS
);

  logic                    iMemRen;
  logic [BLOCK_ADDR_W-1:0] iBlockAddr;
  logic                    iMemReadReady;
  logic [BLOCK_W-1:0]      iMemDout;

  logic                    dMemRen;
  logic                    dMemWen;
  logic [BLOCK_ADDR_W-1:0] dBlockAddr;
  logic [BLOCK_W-1:0]      dMemDin;
  logic                    dMemReadReady;
  logic                    dMemWriteReady;
  logic [BLOCK_W-1:0]      dMemDout;

  logic                    memRen;
  logic                    memWen;
  logic [BLOCK_ADDR_W-1:0] memBlockAddr;
  logic [BLOCK_W-1:0]      memDin;
  logic                    memReadReady;
  logic                    memWriteReady;
  logic [BLOCK_W-1:0]      memDout;

  // Arbiter's view.
  modport slave (
    input  iMemRen, iBlockAddr,
    output iMemReadReady, iMemDout,
    input  dMemRen, dMemWen, dBlockAddr, dMemDin,
    output dMemReadReady, dMemWriteReady, dMemDout,
    output memRen, memWen, memBlockAddr, memDin,
    input  memReadReady, memWriteReady, memDout
  );

  // Environment's view: controllers plus memory.
  modport master (
    output iMemRen, iBlockAddr,
    input  iMemReadReady, iMemDout,
    output dMemRen, dMemWen, dBlockAddr, dMemDin,
    input  dMemReadReady, dMemWriteReady, dMemDout,
    input  memRen, memWen, memBlockAddr, memDin,
    output memReadReady, memWriteReady, memDout
  );

endinterface

// File: rtl/l1_mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a tie goes to the side that was not granted last.
module rr_arb2
  import l1_mem_arbiter_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  gnt_e       last_grant,
  output logic [1:0] gnt          // bit 0 = I side, bit 1 = D side
);

  always_comb begin
    gnt = '0;
    if (req_i && req_d) begin
      gnt = (last_grant == GNT_D) ? 2'b01 : 2'b10;
    end else begin
      gnt = {req_d, req_i};
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one main-memory port between the I and D L1 controllers; each grant
// is held for a whole memory transaction.
module l1_mem_arbiter
  import l1_mem_arbiter_pkg::*;
#(
  parameter int unsigned BLOCK_ADDR_W = IMEM_BLOCK_ADDR_SIZE,
  parameter int unsigned BLOCK_W      = IBLOCK_SIZE_BITS
)(
  input logic           clock,
  input logic           reset,
  l1_mem_arbiter_if.slave bus
);

  arb_state_e              state_q, state_d;
  gnt_e                    last_grant_q, last_grant_d;
  logic                    mem_ren_q, mem_ren_d;
  logic                    mem_wen_q, mem_wen_d;
  logic [BLOCK_ADDR_W-1:0] addr_q, addr_d;
  logic [BLOCK_W-1:0]      din_q, din_d;

  logic       d_req;
  logic [1:0] gnt;
  logic       rd_done;
  logic       wr_done;
  logic       i_rd_rdy;
  logic       d_rd_rdy;
  logic       d_wr_rdy;

  assign d_req = bus.dMemRen | bus.dMemWen;

  rr_arb2 u_rr_arb2 (
    .req_i      (bus.iMemRen),
    .req_d      (d_req),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_ren_d    = mem_ren_q;
    mem_wen_d    = mem_wen_q;
    addr_d       = addr_q;
    din_d        = din_q;
    i_rd_rdy     = 1'b0;
    d_rd_rdy     = 1'b0;
    d_wr_rdy     = 1'b0;
    // Only the strobe matching the latched op completes; the op flops are low in IDLE.
    rd_done      = mem_ren_q & bus.memReadReady;
    wr_done      = mem_wen_q & bus.memWriteReady;

    unique case (state_q)
      ARB_IDLE: begin
        if (gnt[0]) begin
          state_d      = ARB_BUSY_I;
          last_grant_d = GNT_I;
          addr_d       = bus.iBlockAddr;
          mem_ren_d    = 1'b1;
          mem_wen_d    = 1'b0;
        end else if (gnt[1]) begin
          state_d      = ARB_BUSY_D;
          last_grant_d = GNT_D;
          addr_d       = bus.dBlockAddr;
          din_d        = bus.dMemDin;
          // Write wins when both D requests are raised together.
          mem_wen_d    = bus.dMemWen;
          mem_ren_d    = ~bus.dMemWen;
        end
      end
      ARB_BUSY_I: begin
        i_rd_rdy = rd_done;
        if (rd_done || wr_done) begin
          state_d   = ARB_IDLE;
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
        end
      end
      ARB_BUSY_D: begin
        d_rd_rdy = rd_done;
        d_wr_rdy = wr_done;
        if (rd_done || wr_done) begin
          state_d   = ARB_IDLE;
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_ren_d = 1'b0;
        mem_wen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GNT_D;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_ren_q    <= mem_ren_d;
      mem_wen_q    <= mem_wen_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
    end
  end

  assign bus.memRen         = mem_ren_q;
  assign bus.memWen         = mem_wen_q;
  assign bus.memBlockAddr   = addr_q;
  assign bus.memDin         = din_q;
  assign bus.iMemReadReady  = i_rd_rdy;
  assign bus.dMemReadReady  = d_rd_rdy;
  assign bus.dMemWriteReady = d_wr_rdy;
  assign bus.iMemDout       = bus.memDout;
  assign bus.dMemDout       = bus.memDout;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed bench for l1_mem_arbiter: inputs change and outputs are sampled on
// the falling edge, away from the active rising edge.
module tb_l1_mem_arbiter;
  import l1_mem_arbiter_pkg::*;

  logic clock;
  logic reset;

  int unsigned n_checks;
  int unsigned n_pass;

  l1_mem_arbiter_if #(
    .BLOCK_ADDR_W (IMEM_BLOCK_ADDR_SIZE),
    .BLOCK_W      (IBLOCK_SIZE_BITS)
  ) bif ();

  l1_mem_arbiter #(
    .BLOCK_ADDR_W (IMEM_BLOCK_ADDR_SIZE),
    .BLOCK_W      (IBLOCK_SIZE_BITS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    bif.iMemRen = 1'b0;       bif.iBlockAddr = '0;
    bif.dMemRen = 1'b0;       bif.dMemWen = 1'b0;
    bif.dBlockAddr = '0;      bif.dMemDin = '0;
    bif.memReadReady = 1'b0;  bif.memWriteReady = 1'b0;
    bif.memDout = 32'h1234_5678;
    step(); step();

    // Reset state
    check_eq("rst_memRen", bif.memRen, 0);
    check_eq("rst_memWen", bif.memWen, 0);
    check_eq("rst_addr", bif.memBlockAddr, 0);
    check_eq("rst_din", bif.memDin, 0);
    check_eq("rst_istrobe", bif.iMemReadReady, 0);
    check_eq("rst_dstrobes", {bif.dMemReadReady, bif.dMemWriteReady}, 0);
    check_eq("rst_iDout", bif.iMemDout, 64'h1234_5678);
    check_eq("rst_dDout", bif.dMemDout, 64'h1234_5678);
    check_eq("rst_state", dut.state_q, ARB_IDLE);

    // I-only refill, memory answers in cycle 5
    reset = 1'b0;
    bif.iMemRen = 1'b1; bif.iBlockAddr = 8'h0F;
    step();
    for (int unsigned c = 1; c <= 4; c++) begin
      check_eq("ionly_memRen", bif.memRen, 1);
      check_eq("ionly_addr", bif.memBlockAddr, 64'h0F);
      check_eq("ionly_nostrobe", bif.iMemReadReady, 0);
      step();
    end
    check_eq("ionly_memRen_c5", bif.memRen, 1);
    bif.memReadReady = 1'b1; bif.memDout = 32'hAAAA_AAA0;
    #1;
    check_eq("ionly_istrobe", bif.iMemReadReady, 1);
    check_eq("ionly_iDout", bif.iMemDout, 64'hAAAA_AAA0);
    check_eq("ionly_no_dstrobe", bif.dMemReadReady, 0);
    step();
    bif.memReadReady = 1'b0; bif.iMemRen = 1'b0;
    check_eq("ionly_memRen_c6", bif.memRen, 0);
    check_eq("ionly_state_c6", dut.state_q, ARB_IDLE);
    step();

    // Simultaneous requests straight after reset: I first, then D
    reset = 1'b1;
    step();
    reset = 1'b0;
    bif.iMemRen = 1'b1; bif.iBlockAddr = 8'h11;
    bif.dMemRen = 1'b1; bif.dBlockAddr = 8'h22;
    step();
    check_eq("sim1_memRen", bif.memRen, 1);
    check_eq("sim1_addr_I", bif.memBlockAddr, 64'h11);
    step();
    bif.memReadReady = 1'b1; bif.memDout = 32'hC0DE_0001;
    #1;
    check_eq("sim1_istrobe", bif.iMemReadReady, 1);
    check_eq("sim1_no_dstrobe", bif.dMemReadReady, 0);
    step();
    bif.memReadReady = 1'b0; bif.iMemRen = 1'b0;
    check_eq("sim1_turnaround", bif.memRen, 0);
    step();
    check_eq("sim1_memRen_D", bif.memRen, 1);
    check_eq("sim1_addr_D", bif.memBlockAddr, 64'h22);
    bif.memReadReady = 1'b1;
    #1;
    check_eq("sim1_dstrobe", bif.dMemReadReady, 1);
    check_eq("sim1_no_istrobe", bif.iMemReadReady, 0);
    step();
    // D still high in the cycle after its strobe counts as a new request; I joins
    bif.memReadReady = 1'b0; bif.iMemRen = 1'b1;
    step();
    check_eq("sim2_addr_I", bif.memBlockAddr, 64'h11);
    check_eq("sim2_lastgrant", dut.last_grant_q, GNT_I);
    bif.memReadReady = 1'b1;
    #1;
    check_eq("sim2_istrobe", bif.iMemReadReady, 1);
    step();
    bif.memReadReady = 1'b0; bif.iMemRen = 1'b0;
    step();
    check_eq("sim2_addr_D", bif.memBlockAddr, 64'h22);
    check_eq("sim2_lastgrant_D", dut.last_grant_q, GNT_D);
    bif.memReadReady = 1'b1;
    #1;
    check_eq("sim2_dstrobe", bif.dMemReadReady, 1);
    step();
    bif.memReadReady = 1'b0; bif.dMemRen = 1'b0;
    step();

    // D writeback with a stray read strobe mid-transaction
    bif.dMemWen = 1'b1; bif.dBlockAddr = 8'h0A; bif.dMemDin = 32'hFFFF_FFFF;
    step();
    check_eq("wb_memWen", bif.memWen, 1);
    check_eq("wb_memRen", bif.memRen, 0);
    check_eq("wb_addr", bif.memBlockAddr, 64'h0A);
    check_eq("wb_din", bif.memDin, 64'hFFFF_FFFF);
    bif.memReadReady = 1'b1;
    #1;
    check_eq("wb_no_rd_strobe", bif.dMemReadReady, 0);
    check_eq("wb_no_wr_strobe", bif.dMemWriteReady, 0);
    step();
    bif.memReadReady = 1'b0;
    check_eq("wb_still_busy", bif.memWen, 1);
    bif.memWriteReady = 1'b1;
    #1;
    check_eq("wb_wr_strobe", bif.dMemWriteReady, 1);
    check_eq("wb_rd_strobe_off", bif.dMemReadReady, 0);
    step();
    bif.memWriteReady = 1'b0; bif.dMemWen = 1'b0;
    check_eq("wb_done_memWen", bif.memWen, 0);
    check_eq("wb_din_hold", bif.memDin, 64'hFFFF_FFFF);
    check_eq("wb_addr_hold", bif.memBlockAddr, 64'h0A);
    step();

    // Illegal D op: write wins, then reset while BUSY_D
    bif.dMemRen = 1'b1; bif.dMemWen = 1'b1;
    bif.dBlockAddr = 8'h05; bif.dMemDin = 32'h5555_5555;
    step();
    check_eq("ill_memWen", bif.memWen, 1);
    check_eq("ill_memRen", bif.memRen, 0);
    check_eq("ill_state", dut.state_q, ARB_BUSY_D);
    reset = 1'b1;
    step();
    bif.dMemRen = 1'b0; bif.dMemWen = 1'b0;
    check_eq("rstbusy_memRen", bif.memRen, 0);
    check_eq("rstbusy_memWen", bif.memWen, 0);
    check_eq("rstbusy_addr", bif.memBlockAddr, 0);
    check_eq("rstbusy_din", bif.memDin, 0);
    check_eq("rstbusy_state", dut.state_q, ARB_IDLE);
    reset = 1'b0;
    bif.iMemRen = 1'b1; bif.iBlockAddr = 8'h33;
    bif.dMemRen = 1'b1; bif.dBlockAddr = 8'h44;
    step();
    check_eq("rstbusy_I_first", bif.memBlockAddr, 64'h33);
    check_eq("rstbusy_I_memRen", bif.memRen, 1);
    bif.memReadReady = 1'b1;
    #1;
    check_eq("rstbusy_istrobe", bif.iMemReadReady, 1);
    step();
    bif.memReadReady = 1'b0; bif.iMemRen = 1'b0; bif.dMemRen = 1'b0;
    step();

    // Stray strobes while IDLE
    check_eq("stray_pre_state", dut.state_q, ARB_IDLE);
    bif.memReadReady = 1'b1; bif.memWriteReady = 1'b1;
    #1;
    check_eq("stray_istrobe", bif.iMemReadReady, 0);
    check_eq("stray_dstrobes", {bif.dMemReadReady, bif.dMemWriteReady}, 0);
    step();
    bif.memReadReady = 1'b0; bif.memWriteReady = 1'b0;
    check_eq("stray_state", dut.state_q, ARB_IDLE);
    check_eq("stray_memreq", {bif.memRen, bif.memWen}, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
